// File: rtl/bluetooth_uart_tx.sv
// 8N1 UART serializer for packed AT command frames from bluetooth_encoder.
// Sends bytes LSB first. An RX command stops at its CR; TX and error frames send every byte.
module bluetooth_uart_tx #(
    parameter int CLKS_PER_BIT          = 434,
    parameter int MAX_BYTES             = 18,
    parameter int SHORT_LEN             = 13,
    parameter int ASCII_CARRIAGE_RETURN = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [143:0] frame_data,
    input  logic         start,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic [4:0]   byte_count
);
    localparam int             BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

    state_t          r_state, w_state_n;
    logic [BW-1:0]   r_baud, w_baud_n;
    logic [2:0]      r_bit, w_bit_n;
    logic [4:0]      r_idx, w_idx_n;
    logic [4:0]      r_cnt, w_cnt_n;
    logic [17:0][7:0] r_frame;
    logic            r_tx, w_tx_n;
    logic            r_busy, w_busy_n;
    logic            r_done, w_done_n;
    logic            w_load;
    logic [7:0]      w_byte;
    logic            w_baud_end;
    logic            w_last;
    logic [2:0]      w_bit_inc;

    assign w_byte     = r_frame[r_idx];
    assign w_baud_end = (r_baud == BAUD_MAX);
    assign w_bit_inc  = r_bit + 3'd1;
    // Only the final slot, or a CR sitting exactly in the short-frame slot, ends a frame.
    assign w_last     = (r_idx == 5'(MAX_BYTES - 1)) ||
                        ((r_idx == 5'(SHORT_LEN - 1)) && (w_byte == 8'(ASCII_CARRIAGE_RETURN)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_frame <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_idx   <= w_idx_n;
            r_cnt   <= w_cnt_n;
            r_tx    <= w_tx_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            if (w_load) r_frame <= frame_data;
        end
    end

    // tx is registered alongside the state so the line never glitches between bits.
    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud;
        w_bit_n   = r_bit;
        w_idx_n   = r_idx;
        w_cnt_n   = r_cnt;
        w_tx_n    = r_tx;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_n   = 1'b1;
                w_baud_n = '0;
                if (start) begin
                    w_load    = 1'b1;
                    w_idx_n   = '0;
                    w_cnt_n   = '0;
                    w_busy_n  = 1'b1;
                    w_tx_n    = 1'b0;
                    w_state_n = START_BIT;
                end
            end
            START_BIT: begin
                w_tx_n = 1'b0;
                if (w_baud_end) begin
                    w_baud_n  = '0;
                    w_bit_n   = '0;
                    w_tx_n    = w_byte[0];
                    w_state_n = DATA_BITS;
                end else begin
                    w_baud_n = r_baud + BW'(1);
                end
            end
            DATA_BITS: begin
                w_tx_n = w_byte[r_bit];
                if (w_baud_end) begin
                    w_baud_n = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_n    = 1'b1;
                        w_state_n = STOP_BIT;
                    end else begin
                        w_bit_n = w_bit_inc;
                        w_tx_n  = w_byte[w_bit_inc];
                    end
                end else begin
                    w_baud_n = r_baud + BW'(1);
                end
            end
            STOP_BIT: begin
                w_tx_n = 1'b1;
                if (w_baud_end) begin
                    w_baud_n = '0;
                    w_cnt_n  = r_cnt + 5'd1;
                    if (w_last) begin
                        w_done_n  = 1'b1;
                        w_busy_n  = 1'b0;
                        w_state_n = IDLE;
                    end else begin
                        w_idx_n   = r_idx + 5'd1;
                        w_tx_n    = 1'b0;
                        w_state_n = START_BIT;
                    end
                end else begin
                    w_baud_n = r_baud + BW'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign byte_count = r_cnt;
endmodule

// File: doc/bluetooth_uart_tx.md
Name: bluetooth_uart_tx

Overview:
Serializer stage directly downstream of bluetooth_encoder. It latches the 144-bit packed AT command frame (byte 0 in bits [7:0], byte 17 in bits [143:136]) on a start pulse and transmits it byte-by-byte as 8N1 UART to the BLE module. Frame length is resolved on the fly: an RX command ends at its carriage return (13 bytes), while TX commands and the all-0xFF error frame send the full 18 bytes. It asserts done when the last stop bit completes.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2
MAX_BYTES, 18, maximum bytes per frame; must be <= 18
SHORT_LEN, 13, byte count at which a CR terminator ends the frame early
ASCII_CARRIAGE_RETURN, 13, terminator byte value

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
frame_data  input  144  packed command frame; byte i in bits [8i+7:8i]
start  input  1  request to send frame_data; sampled on rising clk edge
tx  output  1  UART serial line, idle high
busy  output  1  high from the cycle after start is accepted until done pulses
done  output  1  single-cycle pulse when the frame is fully sent
byte_count  output  5  bytes fully sent in current or last frame

Behaviour:
- Reset (async, active-high): tx=1, busy=0, done=0, byte_count=0, state=IDLE, bit/baud counters=0, frame register=0. Reset mid-frame aborts immediately: tx returns high in the same instant, with no partial stop bit.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE: tx=1. When start=1 at edge E0: latch frame_data, set byte index=0, set byte_count=0, busy=1, go to START_BIT. start is ignored while busy=1, and the frame register does not change.
- START_BIT: tx=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after E0.
- DATA_BITS: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. At the end of STOP_BIT, byte_count increments and the terminate check runs on the byte just sent (index i):
  - stop if i == MAX_BYTES-1;
  - stop if i == SHORT_LEN-1 and the byte == ASCII_CARRIAGE_RETURN;
  - otherwise i++ and go straight to START_BIT (no inter-byte idle gap).
- CR bytes at any other index, including inside the payload, do not terminate the frame.
- On stop: done=1 for exactly one cycle, busy=0 in that same cycle, return to IDLE.
- A start asserted in the done cycle is accepted; back-to-back frames are legal.
- Timing: each byte occupies 10*CLKS_PER_BIT cycles. An N-byte frame has tx low first on cycle E0+1, and done is high on cycle E0+1+10*N*CLKS_PER_BIT.
- byte_count holds its final value in IDLE until the next accepted start.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps. The bit counter is 3 bits, and the byte index saturates logic at MAX_BYTES-1.

Test Plan:
(All tests use CLKS_PER_BIT=4.)
1. RX frame: "AT+BLEUARTRX" + 0x0D at byte 12, zeros above, start pulse -> 13 bytes decoded on tx, byte_count=13, done pulses exactly at E0+1+520, zero bytes never sent.
2. TX frame: "AT+BLEUARTTX=" + 0x31,0x32,0x0D,0x34 + 0x0D -> all 18 bytes sent, including the embedded 0x0D at byte 15; byte_count=18; done at E0+721.
3. Error frame of all 0xFF (no CR at index 12) -> 18 bytes of 0xFF, each with correct start/stop framing.
4. start re-pulsed at byte 5 with a different frame_data -> ignored; original frame sent unchanged; a single done pulse.
5. reset asserted mid DATA_BITS of byte 3 -> tx=1, busy=0, byte_count=0 immediately; a new start after release sends the frame from byte 0.
6. start held high through done -> second frame begins the cycle after done; tx goes low at done+1 with no idle bit between frames.
